// File: rtl/heq_scaler.sv
// heq_scaler: histogram-equalisation scaler g = (cdf_in-cdf_min)*(2^LBITS-1)/(num_pixels-cdf_min) using a restoring divider.
// Optional round-half-up build: define HEQ_SCALER_ROUND_EN.
module heq_scaler #(
    parameter int CDF_W = 32,
    parameter int LBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CDF_W-1:0] cdf_in,
    input  logic [CDF_W-1:0] cdf_min,
    input  logic [CDF_W-1:0] num_pixels,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LBITS-1:0] g_out,
    output logic             out_sat,
    output logic             out_dz
);
`ifdef HEQ_SCALER_ROUND_EN
    localparam int ITER = LBITS + 1;
`else
    localparam int ITER = LBITS;
`endif
    localparam int NW = CDF_W + LBITS;
    localparam int DW = CDF_W + ITER;
    localparam int CW = $clog2(ITER);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [CDF_W-1:0] rem, d;
    logic [ITER-1:0] sh, sh_nx;
    logic [CW-1:0] cnt;
    logic [NW-1:0] n;
    logic [DW-1:0] dvd;
    logic [CDF_W:0] t;
    logic [LBITS-1:0] g_calc;
    logic ge, accept, last, f_zero, f_dz, f_sat, f_low, forced;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid & in_ready;
    assign last      = (state == CALC) && (cnt == CW'(ITER - 1));
    assign f_zero    = cdf_in == '0;
    assign f_dz      = num_pixels <= cdf_min;
    assign f_sat     = cdf_in > num_pixels;
    assign f_low     = cdf_in <= cdf_min;
    assign forced    = f_zero | f_dz | f_sat | f_low;
    assign n         = NW'(cdf_in - cdf_min) * NW'({LBITS{1'b1}});
    // The quotient fits in ITER bits, so the upper dividend bits already sit below D and seed the remainder.
    assign t         = {rem, sh[ITER-1]};
    assign ge        = t >= {1'b0, d};
    assign sh_nx     = {sh[ITER-2:0], ge};
`ifdef HEQ_SCALER_ROUND_EN
    assign dvd       = {n, 1'b0};
    assign g_calc    = sh_nx[ITER-1:1] + LBITS'(sh_nx[0]);
`else
    assign dvd       = n;
    assign g_calc    = sh_nx;
`endif

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = forced ? DONE : CALC;
        else if (last)
            state_nx = DONE;
        else if (out_valid && out_ready)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem     <= '0;
            d       <= '0;
            sh      <= '0;
            cnt     <= '0;
            g_out   <= '0;
            out_sat <= 1'b0;
            out_dz  <= 1'b0;
        end else if (accept) begin
            rem     <= dvd[DW-1:ITER];
            sh      <= dvd[ITER-1:0];
            d       <= num_pixels - cdf_min;
            cnt     <= '0;
            g_out   <= (!f_zero && (f_dz || f_sat)) ? '1 : '0;
            out_dz  <= !f_zero && f_dz;
            out_sat <= !f_zero && !f_dz && f_sat;
        end else if (state == CALC) begin
            rem <= ge ? t[CDF_W-1:0] - d : t[CDF_W-1:0];
            sh  <= sh_nx;
            cnt <= cnt + CW'(1);
            if (last)
                g_out <= g_calc;
        end
    end
endmodule

// File: tb/tb_heq_scaler.sv
// tb_heq_scaler: directed vector table plus backpressure, mid-divide reset and a random stream for heq_scaler.
module tb_heq_scaler;
`ifdef HEQ_SCALER_ROUND_EN
    localparam int ITER = 9;
`else
    localparam int ITER = 8;
`endif
    logic clk = 0, reset = 1, in_valid = 0, out_valid, in_ready, out_sat, out_dz;
    logic or_manual = 1, rnd_bit = 1, rnd_en = 0, out_ready;
    logic [31:0] cdf_in = 0, cdf_min = 0, num_pixels = 0;
    logic [7:0] g_out;
    int n_cmp = 0, n_fail = 0, n_rx = 0;
    bit mon_en = 0;
    int exp_q[$];

    typedef struct {int cdf; int mn; int np; int gt; int gr; int sat; int dz; int dv;} vec_t;
    vec_t vt[14];

    assign out_ready = rnd_en ? rnd_bit : or_manual;

    heq_scaler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cdf_in(cdf_in), .cdf_min(cdf_min), .num_pixels(num_pixels),
        .out_valid(out_valid), .out_ready(out_ready), .g_out(g_out),
        .out_sat(out_sat), .out_dz(out_dz)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model(input longint cdf, input longint mn, input longint np);
        longint num, den;
        if (cdf == 0) return 0;
        if (np <= mn) return 255 | (1 << 9);
        if (cdf > np) return 255 | (1 << 8);
        if (cdf <= mn) return 0;
        num = (cdf - mn) * 255;
        den = np - mn;
`ifdef HEQ_SCALER_ROUND_EN
        return int'(((2 * num) / den + 1) / 2);
`else
        return int'(num / den);
`endif
    endfunction

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            n_rx++;
            if (exp_q.size() == 0)
                chk("stream extra result", 1, 0);
            else
                chk($sformatf("stream #%0d result", n_rx), int'({out_dz, out_sat, g_out}), exp_q.pop_front());
        end
    end

    task automatic run_one(input string nm, input int cdf, input int mn, input int np,
                           input int eg, input int es, input int ed, input int el);
        int lat;
        @(negedge clk);
        cdf_in = cdf; cdf_min = mn; num_pixels = np; in_valid = 1;
        chk({nm, " in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        cdf_in = $urandom_range(0, 2000); cdf_min = $urandom; num_pixels = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        chk({nm, " latency"}, lat, el);
        chk({nm, " g_out"}, int'(g_out), eg);
        chk({nm, " out_sat"}, int'(out_sat), es);
        chk({nm, " out_dz"}, int'(out_dz), ed);
    endtask

    initial begin
        int g0, bound, v;
        vt[0]  = '{850, 100, 1600, 127, 128, 0, 0, 1};
        vt[1]  = '{1600, 100, 1600, 255, 255, 0, 0, 1};
        vt[2]  = '{101, 100, 1600, 0, 0, 0, 0, 1};
        vt[3]  = '{0, 100, 1600, 0, 0, 0, 0, 0};
        vt[4]  = '{1700, 100, 1600, 255, 255, 1, 0, 0};
        vt[5]  = '{1600, 1600, 1600, 255, 255, 0, 1, 0};
        vt[6]  = '{100, 100, 1600, 0, 0, 0, 0, 0};
        vt[7]  = '{1601, 100, 1600, 255, 255, 1, 0, 0};
        vt[8]  = '{0, 1600, 1600, 0, 0, 0, 0, 0};
        vt[9]  = '{1100, 100, 1600, 170, 170, 0, 0, 1};
        vt[10] = '{400, 100, 1600, 51, 51, 0, 0, 1};
        vt[11] = '{175, 100, 1600, 12, 13, 0, 0, 1};
        vt[12] = '{3, 0, 1000, 0, 1, 0, 0, 1};
        vt[13] = '{1000, 0, 1000, 255, 255, 0, 0, 1};

        repeat (2) @(negedge clk);
        reset = 0;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset g_out", int'(g_out), 0);
        chk("reset out_sat", int'(out_sat), 0);
        chk("reset out_dz", int'(out_dz), 0);

        foreach (vt[i]) begin
`ifdef HEQ_SCALER_ROUND_EN
            v = vt[i].gr;
`else
            v = vt[i].gt;
`endif
            run_one($sformatf("vec%0d", i), vt[i].cdf, vt[i].mn, vt[i].np, v, vt[i].sat, vt[i].dz,
                    vt[i].dv != 0 ? ITER + 1 : 1);
        end

        // Backpressure: result held while out_ready is low, in_valid pulses ignored.
        @(negedge clk);
        or_manual = 0;
        run_one("bp", 850, 100, 1600, (ITER == 9) ? 128 : 127, 0, 0, ITER + 1);
        g0 = int'(g_out);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            cdf_in = 0; cdf_min = 100; num_pixels = 1600;
            chk($sformatf("bp out_valid c%0d", k), int'(out_valid), 1);
            chk($sformatf("bp g_out c%0d", k), int'(g_out), g0);
            chk($sformatf("bp in_ready c%0d", k), int'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 0;
        or_manual = 1;
        @(negedge clk);
        chk("bp in_ready after release", int'(in_ready), 1);
        chk("bp out_valid after release", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        chk("bp no stray accept", int'(in_ready), 1);

        // Reset during the fourth divide cycle, with in_valid asserted alongside.
        @(negedge clk);
        cdf_in = 850; cdf_min = 100; num_pixels = 1600; in_valid = 1;
        @(posedge clk);
        #1;
        cdf_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        in_valid = 0;
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst g_out", int'(g_out), 0);
        run_one("post-rst", 850, 100, 1600, (ITER == 9) ? 128 : 127, 0, 0, ITER + 1);

        // Random stream with random backpressure.
        @(negedge clk);
        mon_en = 1;
        rnd_en = 1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cdf_in = $urandom_range(0, 2000);
            cdf_min = (i % 16 == 15) ? 1700 : 100;
            num_pixels = 1600;
            in_valid = 1;
            bound = 0;
            while (!in_ready && bound < 200) begin
                @(negedge clk);
                bound++;
            end
            if (bound >= 200) chk("stream accept timeout", 1, 0);
            @(posedge clk);
            exp_q.push_back(model(cdf_in, cdf_min, num_pixels));
            #1;
            in_valid = 0;
        end
        bound = 0;
        while (n_rx < 256 && bound < 2000) begin
            @(negedge clk);
            bound++;
        end
        chk("stream result count", n_rx, 256);
        chk("stream leftover", exp_q.size(), 0);
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
